// File: rtl/frame_uart_streamer_pkg.sv
// Shared definitions for the frame-to-UART streamer: FSM state encoding and
// the width of the frame-decimation control.
package frame_uart_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_WAIT,
    ST_HEADER,
    ST_FETCH,
    ST_SEND,
    ST_TX_WAIT,
    ST_GAP,
    ST_POST_WAIT
  } state_e;

  localparam int SKIP_W = 4;

endpackage

// File: rtl/frame_uart_streamer_if.sv
// Bus bundle between the streamer, the frame RAM read port and the UART Tx.
// The master side is the streamer; the slave side is the RAM/Tx pair.
interface frame_uart_streamer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] o_Rd_Addr;
  logic              o_Rd_En;
  logic [DATA_W-1:0] i_Rd_Data;
  logic              o_Tx_Start;
  logic [DATA_W-1:0] o_Tx_Data;
  logic              i_Tx_Busy;

  modport master (
    output o_Rd_Addr, o_Rd_En, o_Tx_Start, o_Tx_Data,
    input  i_Rd_Data, i_Tx_Busy
  );

  modport slave (
    input  o_Rd_Addr, o_Rd_En, o_Tx_Start, o_Tx_Data,
    output i_Rd_Data, i_Tx_Busy
  );

endinterface

// File: rtl/frame_uart_streamer_vs_edge_sync.sv
// Two-flop synchroniser for an asynchronous strobe plus a rising-edge detector.
// o_Rise is a single-cycle pulse in the Clk domain.
module frame_uart_streamer_vs_edge_sync (
  input  logic Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the async input and keep the previous synchronised value.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_Async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_Rise = r_sync & ~r_prev;

endmodule

// File: rtl/frame_uart_streamer.sv
// Streams one frame from the camera frame RAM to the UART Tx after a
// qualified VSYNC rising edge, with decimation, optional header byte,
// Tx busy handshake, RAM latency alignment and abort.
module frame_uart_streamer
  import frame_uart_streamer_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 15,
  parameter int unsigned       DATA_W          = 8,
  parameter int unsigned       BYTES_PER_FRAME = 9216,
  parameter int unsigned       CNT_W           = 26,
  parameter int unsigned       PRE_WAIT_CYC    = 62500000,
  parameter int unsigned       POST_WAIT_CYC   = 62500000,
  parameter int unsigned       GAP_CYC         = 1085,
  parameter int unsigned       RD_LAT          = 1,
  parameter bit                HEADER_EN       = 1'b1,
  parameter logic [DATA_W-1:0] HEADER_BYTE     = 8'hA5
) (
  input  logic                 Clk,
  input  logic                 i_Rst,
  input  logic                 i_VS,
  input  logic [SKIP_W-1:0]    i_Skip,
  input  logic                 i_Abort,
  frame_uart_streamer_if.master bus,
  output logic                 o_Frame_Indicator,
  output logic                 o_Busy,
  output logic                 o_Frame_Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

  // A wait of cyc cycles ends when the per-state counter reaches cyc-1.
  function automatic logic cnt_hit(input logic [CNT_W-1:0] cnt, input int unsigned cyc);
    if (cyc == 0) return 1'b1;
    return cnt == CNT_W'(cyc - 1);
  endfunction

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_tx_data;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [RD_LAT-1:0]   r_vld;
  logic                r_rd_pend;
  logic                r_prev_data;
  logic                r_abort_pend;
  logic                r_frame_done;

  logic w_vs_rise;
  logic w_rd_en;
  logic w_tx_start;
  logic w_capture;
  logic w_load_hdr;
  logic w_addr_clr;
  logic w_addr_inc;
  logic w_done;
  logic w_skip_clr;
  logic w_skip_inc;
  logic w_last_data;
  state_e w_gap_dst;

  frame_uart_streamer_vs_edge_sync u_vs_sync (
    .Clk    (Clk),
    .i_Rst  (i_Rst),
    .i_Async(i_VS),
    .o_Rise (w_vs_rise)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_tx_start  = 1'b0;
    w_capture   = 1'b0;
    w_load_hdr  = 1'b0;
    w_addr_clr  = 1'b0;
    w_addr_inc  = 1'b0;
    w_done      = 1'b0;
    w_skip_clr  = 1'b0;
    w_skip_inc  = 1'b0;
    w_last_data = r_prev_data && (r_addr == LAST_ADDR);
    w_gap_dst   = w_last_data ? ST_POST_WAIT : ST_FETCH;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          if (r_skip_cnt == i_Skip) begin
            w_skip_clr  = 1'b1;
            w_state_nxt = ST_PRE_WAIT;
          end else begin
            w_skip_inc = 1'b1;
          end
        end
      end
      ST_PRE_WAIT: begin
        if (i_Abort) begin
          w_state_nxt = ST_POST_WAIT;
        end else if (cnt_hit(r_cnt, PRE_WAIT_CYC)) begin
          w_addr_clr = 1'b1;
          if (HEADER_EN) begin
            w_load_hdr  = 1'b1;
            w_state_nxt = ST_HEADER;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_HEADER, ST_SEND: begin
        if (i_Abort) begin
          w_state_nxt = ST_POST_WAIT;
        end else if (!bus.i_Tx_Busy) begin
          w_tx_start  = 1'b1;
          w_state_nxt = ST_TX_WAIT;
        end
      end
      ST_FETCH: begin
        if (i_Abort) begin
          w_state_nxt = ST_POST_WAIT;
        end else begin
          w_rd_en = !r_rd_pend;
          if (r_vld[RD_LAT-1]) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_TX_WAIT: begin
        // Busy is not yet valid in the first cycle after the start pulse.
        if (r_cnt != '0 && !bus.i_Tx_Busy) begin
          if (r_abort_pend || i_Abort) begin
            w_state_nxt = ST_POST_WAIT;
          end else if (GAP_CYC == 0) begin
            w_state_nxt = w_gap_dst;
            w_done      = w_last_data;
            w_addr_inc  = r_prev_data && !w_last_data;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (i_Abort) begin
          w_state_nxt = ST_POST_WAIT;
        end else if (cnt_hit(r_cnt, GAP_CYC)) begin
          w_state_nxt = w_gap_dst;
          w_done      = w_last_data;
          w_addr_inc  = r_prev_data && !w_last_data;
        end
      end
      ST_POST_WAIT: begin
        if (cnt_hit(r_cnt, POST_WAIT_CYC)) begin
          w_addr_clr  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state cycle counter, cleared on every state change.
  always_ff @(posedge Clk) begin
    if (i_Rst || w_state_nxt != r_state) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 1'b1;
  end

  // Read address: cleared at frame start/end, advanced after each data byte.
  always_ff @(posedge Clk) begin
    if (i_Rst || w_addr_clr) r_addr <= '0;
    else if (w_addr_inc)     r_addr <= r_addr + 1'b1;
  end

  // Tx byte register, stable from start until the next load.
  always_ff @(posedge Clk) begin
    if (i_Rst)           r_tx_data <= '0;
    else if (w_load_hdr) r_tx_data <= HEADER_BYTE;
    else if (w_capture)  r_tx_data <= bus.i_Rd_Data;
  end

  // Frame decimation counter.
  always_ff @(posedge Clk) begin
    if (i_Rst || w_skip_clr) r_skip_cnt <= '0;
    else if (w_skip_inc)     r_skip_cnt <= r_skip_cnt + 1'b1;
  end

  // Read-valid shift register aligning capture to the RAM latency.
  always_ff @(posedge Clk) begin
    if (i_Rst || r_state != ST_FETCH) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_en;
      for (int i = 1; i < int'(RD_LAT); i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // One read per FETCH visit.
  always_ff @(posedge Clk) begin
    if (i_Rst || r_state != ST_FETCH) r_rd_pend <= 1'b0;
    else if (w_rd_en)                 r_rd_pend <= 1'b1;
  end

  // Remember whether the byte in flight was data (vs header) and any abort seen mid-byte.
  always_ff @(posedge Clk) begin
    if (i_Rst) begin
      r_prev_data  <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_tx_start) r_prev_data <= (r_state == ST_SEND);
      r_abort_pend <= (r_state == ST_TX_WAIT) && (r_abort_pend || i_Abort);
    end
  end

  // Frame-complete pulse, visible in the first POST_WAIT cycle.
  always_ff @(posedge Clk) begin
    if (i_Rst) r_frame_done <= 1'b0;
    else       r_frame_done <= w_done;
  end

  assign bus.o_Rd_Addr  = r_addr;
  assign bus.o_Rd_En    = w_rd_en;
  assign bus.o_Tx_Start = w_tx_start;
  assign bus.o_Tx_Data  = r_tx_data;
  assign o_Frame_Indicator = (r_state == ST_IDLE);
  assign o_Busy            = (r_state != ST_IDLE);
  assign o_Frame_Done      = r_frame_done;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: two instances (RD_LAT 1 and 3) share VS,
// skip and reset; each has its own RAM model, Tx model and expected-byte queue.
module tb_frame_uart_streamer;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic vs;
  logic [3:0] skip;

  logic             abort_r   [2];
  logic             hold      [2];
  logic             rd_en     [2];
  logic [AW-1:0]    rd_addr   [2];
  logic             tx_start  [2];
  logic [7:0]       tx_data   [2];
  logic             tx_busy   [2];
  logic             frame_ind [2];
  logic             busy_o    [2];
  logic             fdone     [2];
  int               starts    [2];
  int               dones     [2];
  logic [7:0]       exp_q     [2][$];

  logic [7:0] ram [4];
  logic [7:0] frm [5];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = (g == 0) ? 1 : 3;

    frame_uart_streamer_if #(.ADDR_W(AW), .DATA_W(8)) bus ();

    frame_uart_streamer #(
      .ADDR_W(AW), .DATA_W(8), .BYTES_PER_FRAME(4), .CNT_W(8),
      .PRE_WAIT_CYC(10), .POST_WAIT_CYC(10), .GAP_CYC(3), .RD_LAT(LAT),
      .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)
    ) dut (
      .Clk(clk), .i_Rst(rst), .i_VS(vs), .i_Skip(skip), .i_Abort(abort_r[g]),
      .bus(bus), .o_Frame_Indicator(frame_ind[g]), .o_Busy(busy_o[g]),
      .o_Frame_Done(fdone[g])
    );

    logic [7:0] pipe [LAT];
    int bcnt = 0;

    assign rd_en[g]     = bus.o_Rd_En;
    assign rd_addr[g]   = bus.o_Rd_Addr;
    assign tx_start[g]  = bus.o_Tx_Start;
    assign tx_data[g]   = bus.o_Tx_Data;
    assign tx_busy[g]   = bus.i_Tx_Busy;
    assign bus.i_Rd_Data = pipe[LAT-1];
    assign bus.i_Tx_Busy = (bcnt != 0) || hold[g];

    // RAM with LAT-cycle read latency; junk when no read was issued.
    always @(posedge clk) begin
      pipe[0] <= rd_en[g] ? ram[rd_addr[g][1:0]] : 8'hEE;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Tx model: busy for 20 cycles after each start.
    always @(posedge clk) begin
      if (tx_start[g])    bcnt <= 20;
      else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    // Scoreboard side: compare each started byte against the queue head.
    always @(negedge clk) begin
      if (tx_start[g]) begin
        starts[g] <= starts[g] + 1;
        chk($sformatf("start_busy%0d", g), tx_busy[g], 1'b0);
        chk($sformatf("q_nonempty%0d", g), exp_q[g].size() != 0, 1'b1);
        if (exp_q[g].size() != 0) chk($sformatf("byte%0d", g), tx_data[g], exp_q[g].pop_front());
      end
      if (fdone[g]) dones[g] <= dones[g] + 1;
      if (rd_en[g]) chk($sformatf("rd_addr_rng%0d", g), rd_addr[g] < AW'(4), 1'b1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    cycles(4);
    vs = 1'b0;
  endtask

  task automatic push_frame(input int g, input int n);
    for (int i = 0; i < n; i++) exp_q[g].push_back(frm[i]);
  endtask

  task automatic wait_rd0(input int addr);
    int k = 0;
    while (!(rd_en[0] && rd_addr[0] == AW'(addr)) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("wait_rd", k < 600, 1'b1);
  endtask

  task automatic wait_busy0(input logic val);
    int k = 0;
    while (tx_busy[0] !== val && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("wait_busy", k < 600, 1'b1);
  endtask

  task automatic check_idle_done(input string tag, input int d0, input int d1);
    chk({tag, "_q0"}, exp_q[0].size(), 0);
    chk({tag, "_q1"}, exp_q[1].size(), 0);
    chk({tag, "_done0"}, dones[0], d0);
    chk({tag, "_done1"}, dones[1], d1);
    chk({tag, "_ind0"}, frame_ind[0], 1'b1);
    chk({tag, "_ind1"}, frame_ind[1], 1'b1);
  endtask

  task automatic check_reset_outs(input int g, input string tag);
    chk({tag, "_addr"},  rd_addr[g], 0);
    chk({tag, "_rden"},  rd_en[g], 1'b0);
    chk({tag, "_start"}, tx_start[g], 1'b0);
    chk({tag, "_data"},  tx_data[g], 0);
    chk({tag, "_ind"},   frame_ind[g], 1'b1);
    chk({tag, "_busy"},  busy_o[g], 1'b0);
    chk({tag, "_done"},  fdone[g], 1'b0);
  endtask

  initial begin
    int s0, d0, d1, k;
    ram = '{8'h11, 8'h22, 8'h33, 8'h44};
    frm = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; vs = 1'b0; skip = 4'd0;
    for (int g = 0; g < 2; g++) begin
      abort_r[g] = 1'b0; hold[g] = 1'b0; starts[g] = 0; dones[g] = 0;
    end
    cycles(3);
    check_reset_outs(0, "rst0");
    check_reset_outs(1, "rst1");
    rst = 1'b0;
    cycles(2);

    // Single full frame on both latencies.
    push_frame(0, 5); push_frame(1, 5);
    vs_pulse();
    cycles(400);
    check_idle_done("frame1", 1, 1);
    chk("starts0", starts[0], 5);
    chk("starts1", starts[1], 5);

    // Decimation: one frame per three VS edges.
    skip = 4'd2;
    for (int e = 1; e <= 6; e++) begin
      if (e % 3 == 0) begin push_frame(0, 5); push_frame(1, 5); end
      vs_pulse();
      cycles(300);
      check_idle_done("skip", 1 + e / 3, 1 + e / 3);
    end
    skip = 4'd0;

    // Tx busy held at SEND blocks the start until released.
    push_frame(0, 5); push_frame(1, 5);
    vs_pulse();
    wait_rd0(1);
    hold[0] = 1'b1;
    s0 = starts[0];
    cycles(100);
    chk("hold_nostart", starts[0], s0);
    hold[0] = 1'b0;
    cycles(5);
    chk("hold_onestart", starts[0], s0 + 1);
    cycles(400);
    check_idle_done("hold", 4, 4);

    // Abort during GAP after the second data byte (instance 0 only).
    push_frame(0, 3); push_frame(1, 5);
    d0 = dones[0]; d1 = dones[1];
    s0 = starts[0];
    vs_pulse();
    k = 0;
    while (starts[0] < s0 + 3 && k < 600) begin @(negedge clk); k++; end
    chk("wait_start3", k < 600, 1'b1);
    wait_busy0(1'b1);
    wait_busy0(1'b0);
    cycles(1);
    abort_r[0] = 1'b1;
    cycles(1);
    abort_r[0] = 1'b0;
    cycles(9);
    chk("abort_post9", frame_ind[0], 1'b0);
    cycles(1);
    chk("abort_idle10", frame_ind[0], 1'b1);
    cycles(400);
    check_idle_done("abort", d0, d1 + 1);

    // Reset while instance 0 sits in SEND.
    push_frame(0, 5); push_frame(1, 5);
    vs_pulse();
    wait_rd0(2);
    hold[0] = 1'b1;
    cycles(3);
    chk("pre_rst_busy", busy_o[0], 1'b1);
    rst = 1'b1;
    cycles(1);
    check_reset_outs(0, "midrst0");
    chk("midrst1_ind", frame_ind[1], 1'b1);
    rst = 1'b0;
    hold[0] = 1'b0;
    exp_q[0].delete(); exp_q[1].delete();
    d0 = dones[0]; d1 = dones[1];
    cycles(50);

    // Recovery frame after reset.
    push_frame(0, 5); push_frame(1, 5);
    vs_pulse();
    cycles(400);
    check_idle_done("recover", d0 + 1, d1 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
